// File: rtl/alu_seq_ctrl_if.sv
// Handshake bundle between the ID/EX pipeline stage and the EX-stage ALU sequencer.
// The master is the pipeline side; the slave is alu_seq_ctrl.
interface alu_seq_ctrl_if;
  logic [5:0] funct;
  logic       in_valid;
  logic       flush;
  logic [5:0] ctrl_out;
  logic       div_start;
  logic       mul_start;
  logic       hilo_we;
  logic       busy;
  logic       stall;

  modport master (
    output funct, in_valid, flush,
    input  ctrl_out, div_start, mul_start, hilo_we, busy, stall
  );

  modport slave (
    input  funct, in_valid, flush,
    output ctrl_out, div_start, mul_start, hilo_we, busy, stall
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// EX-stage funct register and DIVU/MULTU sequencer: broadcasts the control code,
// counts multi-cycle ops to a HiLo write strobe and raises pipeline stall/busy.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no multi-cycle op; ctrl_out follows funct, accepts DIVU/MULTU
//   ST_RUN   | DIVU/MULTU in flight; ctrl_out holds the op, cnt counts to limit
//   ST_WRITE | one-cycle HiLo write; a new DIVU/MULTU may be accepted on exit
module alu_seq_ctrl #(
  parameter int          DIV_CYCLES = 32,
  parameter int          MUL_CYCLES = 32,
  parameter int          CNT_W      = 6,
  parameter logic [5:0]  HILO_CODE  = 6'b111111
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  localparam logic [CNT_W-1:0] DIV_LIM = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LIM = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DIV_CYCLES < 1 || DIV_CYCLES > (2**CNT_W) - 1) begin : g_bad_div
    $error("alu_seq_ctrl: DIV_CYCLES out of range for CNT_W");
  end
  if (MUL_CYCLES < 1 || MUL_CYCLES > (2**CNT_W) - 1) begin : g_bad_mul
    $error("alu_seq_ctrl: MUL_CYCLES out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [5:0]       ctrl_out_q, ctrl_out_d;
  logic             div_start_q, div_start_d;
  logic             mul_start_q, mul_start_d;
  logic             hilo_we_q, hilo_we_d;
  logic             busy_q, busy_d;

  logic acc_div;
  logic acc_mul;
  logic hazard;
  logic mc_op;

  assign mc_op   = (bus.funct == F_DIVU) || (bus.funct == F_MULTU);
  assign hazard  = mc_op || (bus.funct == F_MFHI) || (bus.funct == F_MFLO);
  assign acc_div = bus.in_valid && !bus.flush && (bus.funct == F_DIVU);
  assign acc_mul = bus.in_valid && !bus.flush && (bus.funct == F_MULTU);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    ctrl_out_d  = ctrl_out_q;
    div_start_d = 1'b0;
    mul_start_d = 1'b0;
    hilo_we_d   = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          cnt_d      = '0;
          ctrl_out_d = bus.funct;
        end else if (cnt_q == limit_q) begin
          state_d    = ST_WRITE;
          ctrl_out_d = HILO_CODE;
          hilo_we_d  = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // IDLE and WRITE both return to pass-through and may accept a new op
      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        cnt_d      = '0;
        ctrl_out_d = bus.funct;
        if (acc_div) begin
          state_d     = ST_RUN;
          limit_d     = DIV_LIM;
          cnt_d       = CNT_ONE;
          div_start_d = 1'b1;
          busy_d      = 1'b1;
        end else if (acc_mul) begin
          state_d     = ST_RUN;
          limit_d     = MUL_LIM;
          cnt_d       = CNT_ONE;
          mul_start_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      limit_q     <= '0;
      ctrl_out_q  <= '0;
      div_start_q <= 1'b0;
      mul_start_q <= 1'b0;
      hilo_we_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      ctrl_out_q  <= ctrl_out_d;
      div_start_q <= div_start_d;
      mul_start_q <= mul_start_d;
      hilo_we_q   <= hilo_we_d;
      busy_q      <= busy_d;
    end
  end

  // In the WRITE cycle a waiting DIVU/MULTU is let through for back-to-back accept
  assign bus.stall = bus.in_valid && busy_q && hazard &&
                     !((state_q == ST_WRITE) && mc_op);

  assign bus.ctrl_out  = ctrl_out_q;
  assign bus.div_start = div_start_q;
  assign bus.mul_start = mul_start_q;
  assign bus.hilo_we   = hilo_we_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: pass-through, DIVU with MFLO hazard,
// MULTU->DIVU back-to-back, flush at terminal count and async reset mid-run.
module tb_alu_seq_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_seq_ctrl_if bus_a ();
  alu_seq_ctrl_if bus_b ();
  alu_seq_ctrl_if bus_c ();

  alu_seq_ctrl u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

  alu_seq_ctrl #(.DIV_CYCLES(3), .MUL_CYCLES(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  alu_seq_ctrl #(.DIV_CYCLES(5)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] pt_vec [7];
    int         seen_we;
    int         lat;
    n_cmp = 0;
    n_err = 0;
    pt_vec = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd7};

    rst_n = 1'b0;
    bus_a.funct = 6'd36; bus_a.in_valid = 1'b1; bus_a.flush = 1'b0;
    bus_b.funct = 6'd0;  bus_b.in_valid = 1'b0; bus_b.flush = 1'b0;
    bus_c.funct = 6'd0;  bus_c.in_valid = 1'b0; bus_c.flush = 1'b0;
    #12;
    chk("rst_ctrl", 32'(bus_a.ctrl_out), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_hilo", 32'(bus_a.hilo_we), 0);
    chk("rst_dstart", 32'(bus_a.div_start), 0);
    rst_n = 1'b1;

    // single-cycle ops pass through one cycle late, unknown code included
    foreach (pt_vec[i]) begin
      bus_a.funct = pt_vec[i];
      bus_a.in_valid = 1'b1;
      tick();
      chk("pt_ctrl", 32'(bus_a.ctrl_out), 32'(pt_vec[i]));
      chk("pt_busy", 32'(bus_a.busy), 0);
      chk("pt_hilo", 32'(bus_a.hilo_we), 0);
      chk("pt_starts", 32'({bus_a.div_start, bus_a.mul_start}), 0);
      chk("pt_stall", 32'(bus_a.stall), 0);
    end

    // DIVU default 32 cycles, MFLO waiting behind it
    bus_a.funct = 6'd27;
    #1;
    chk("div_pre_stall", 32'(bus_a.stall), 0);
    tick();
    chk("div_start", 32'(bus_a.div_start), 1);
    chk("div_busy0", 32'(bus_a.busy), 1);
    chk("div_ctrl0", 32'(bus_a.ctrl_out), 27);
    bus_a.funct = 6'd18;
    #1;
    chk("mflo_stall0", 32'(bus_a.stall), 1);
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 1) chk("div_start_clr", 32'(bus_a.div_start), 0);
      chk("div_run_ctrl", 32'(bus_a.ctrl_out), 27);
      chk("div_run_busy", 32'(bus_a.busy), 1);
      chk("div_run_hilo", 32'(bus_a.hilo_we), 0);
      chk("mflo_run_stall", 32'(bus_a.stall), 1);
    end
    tick();
    chk("div_wr_ctrl", 32'(bus_a.ctrl_out), 63);
    chk("div_wr_hilo", 32'(bus_a.hilo_we), 1);
    chk("div_wr_busy", 32'(bus_a.busy), 1);
    chk("mflo_wr_stall", 32'(bus_a.stall), 1);
    tick();
    chk("div_done_ctrl", 32'(bus_a.ctrl_out), 18);
    chk("div_done_hilo", 32'(bus_a.hilo_we), 0);
    chk("div_done_busy", 32'(bus_a.busy), 0);
    chk("mflo_done_stall", 32'(bus_a.stall), 0);
    bus_a.in_valid = 1'b0;
    bus_a.funct = 6'd0;

    // MULTU (4) then DIVU (3) back-to-back
    bus_b.funct = 6'd25;
    bus_b.in_valid = 1'b1;
    tick();
    chk("b2b_mstart", 32'(bus_b.mul_start), 1);
    chk("b2b_mctrl", 32'(bus_b.ctrl_out), 25);
    bus_b.funct = 6'd27;
    #1;
    chk("b2b_run_stall", 32'(bus_b.stall), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("b2b_mrun_ctrl", 32'(bus_b.ctrl_out), 25);
      chk("b2b_mrun_hilo", 32'(bus_b.hilo_we), 0);
      chk("b2b_mrun_dstart", 32'(bus_b.div_start), 0);
    end
    tick();
    chk("b2b_mwr_hilo", 32'(bus_b.hilo_we), 1);
    chk("b2b_mwr_ctrl", 32'(bus_b.ctrl_out), 63);
    chk("b2b_wr_stall", 32'(bus_b.stall), 0);
    tick();
    chk("b2b_dstart", 32'(bus_b.div_start), 1);
    chk("b2b_dbusy", 32'(bus_b.busy), 1);
    chk("b2b_dctrl", 32'(bus_b.ctrl_out), 27);
    chk("b2b_dhilo0", 32'(bus_b.hilo_we), 0);
    bus_b.funct = 6'd0;
    bus_b.in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk("b2b_drun_hilo", 32'(bus_b.hilo_we), 0);
    end
    tick();
    chk("b2b_dwr_hilo", 32'(bus_b.hilo_we), 1);
    chk("b2b_dwr_ctrl", 32'(bus_b.ctrl_out), 63);
    tick();
    chk("b2b_idle_busy", 32'(bus_b.busy), 0);
    chk("b2b_idle_ctrl", 32'(bus_b.ctrl_out), 0);

    // flush on the terminal-count edge (DIV_CYCLES=5)
    bus_c.funct = 6'd27;
    bus_c.in_valid = 1'b1;
    tick();
    chk("fl_dstart", 32'(bus_c.div_start), 1);
    bus_c.funct = 6'd0;
    bus_c.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("fl_run_busy", 32'(bus_c.busy), 1);
    end
    bus_c.flush = 1'b1;
    bus_c.funct = 6'd34;
    bus_c.in_valid = 1'b1;
    tick();
    chk("fl_hilo", 32'(bus_c.hilo_we), 0);
    chk("fl_busy", 32'(bus_c.busy), 0);
    chk("fl_ctrl", 32'(bus_c.ctrl_out), 34);
    bus_c.funct = 6'd27;
    tick();
    chk("fl_idle_block", 32'(bus_c.div_start), 0);
    chk("fl_idle_busy", 32'(bus_c.busy), 0);
    chk("fl_idle_ctrl", 32'(bus_c.ctrl_out), 27);
    bus_c.flush = 1'b0;
    bus_c.in_valid = 1'b0;
    bus_c.funct = 6'd0;
    tick();
    chk("fl_after_hilo", 32'(bus_c.hilo_we), 0);

    // async reset mid-run, then a fresh DIVU
    bus_a.funct = 6'd27;
    bus_a.in_valid = 1'b1;
    tick();
    chk("ar_dstart", 32'(bus_a.div_start), 1);
    bus_a.funct = 6'd0;
    bus_a.in_valid = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(bus_a.busy), 0);
    chk("ar_ctrl", 32'(bus_a.ctrl_out), 0);
    chk("ar_hilo", 32'(bus_a.hilo_we), 0);
    chk("ar_starts", 32'({bus_a.div_start, bus_a.mul_start}), 0);
    #2;
    rst_n = 1'b1;
    seen_we = 0;
    repeat (40) begin
      tick();
      if (bus_a.hilo_we || bus_a.busy) seen_we++;
    end
    chk("ar_no_hilo", 32'(seen_we), 0);
    bus_a.funct = 6'd27;
    bus_a.in_valid = 1'b1;
    tick();
    chk("ar2_dstart", 32'(bus_a.div_start), 1);
    bus_a.funct = 6'd0;
    bus_a.in_valid = 1'b0;
    lat = 0;
    while (!bus_a.hilo_we && lat < 40) begin
      tick();
      lat++;
    end
    chk("ar2_latency", 32'(lat), 32);
    tick();
    chk("ar2_done_busy", 32'(bus_a.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
